// File: rtl/inst_fetch_resp_pkg.sv
// Shared constants and state encoding for the
// byte-serial instruction fetch responder.
package inst_fetch_resp_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;
  localparam logic [InstBus-1:0] NopInst  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/inst_fetch_resp.sv
// Fetch responder: reads four bytes from a byte-wide
// synchronous ROM and assembles a little-endian word.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int          ADDR_W   = 17,
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic                   flush_i,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o,
  output logic                   misalign_o,
  output logic                   stall_req_o,
  output logic [ADDR_W-1:0]      mem_a_o,
  output logic                   mem_re_o,
  input  logic [7:0]             mem_din_i
);

  state_e              state, state_n;
  logic [2:0]          cnt, cnt_n;
  logic [ADDR_W-1:0]   base, base_n;
  logic [ADDR_W-1:0]   a_n;
  logic [23:0]         lanes, lanes_n;
  logic [InstBus-1:0]  inst_n;
  logic                valid_n;
  logic                mis_n;
  logic                re_n;
  logic                unused_pc;

  assign stall_req_o = (state != IDLE);
  assign unused_pc   = ^pc_i[InstAddrBus-1:ADDR_W];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      base         <= '0;
      lanes        <= '0;
      inst_o       <= ZeroWord;
      inst_valid_o <= 1'b0;
      misalign_o   <= 1'b0;
      mem_a_o      <= '0;
      mem_re_o     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      base         <= base_n;
      lanes        <= lanes_n;
      inst_o       <= inst_n;
      inst_valid_o <= valid_n;
      misalign_o   <= mis_n;
      mem_a_o      <= a_n;
      mem_re_o     <= re_n;
    end
  end

  // ROM data lags the address by one edge, so the
  // byte for address base+n is captured at edge n+2.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    base_n  = base;
    lanes_n = lanes;
    inst_n  = inst_o;
    valid_n = 1'b0;
    mis_n   = 1'b0;
    a_n     = mem_a_o;
    re_n    = mem_re_o;
    case (state)
      IDLE: begin
        if (ce_i == ChipEnable && !flush_i) begin
          if (pc_i[1:0] == 2'b00) begin
            base_n  = pc_i[ADDR_W-1:0];
            a_n     = pc_i[ADDR_W-1:0];
            re_n    = 1'b1;
            cnt_n   = 3'd1;
            state_n = ISSUE;
          end else begin
            inst_n  = NOP_INST;
            valid_n = 1'b1;
            mis_n   = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (flush_i) begin
          state_n = IDLE;
          re_n    = 1'b0;
          cnt_n   = 3'd0;
        end else begin
          a_n   = base + ADDR_W'(cnt);
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd2) begin
            lanes_n[7:0] = mem_din_i;
          end
          if (cnt == 3'd3) begin
            lanes_n[15:8] = mem_din_i;
            state_n       = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (flush_i) begin
          state_n = IDLE;
          re_n    = 1'b0;
          cnt_n   = 3'd0;
        end else if (cnt == 3'd4) begin
          re_n           = 1'b0;
          lanes_n[23:16] = mem_din_i;
          cnt_n          = 3'd5;
        end else begin
          inst_n  = {mem_din_i, lanes};
          valid_n = 1'b1;
          cnt_n   = 3'd0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        re_n    = 1'b0;
        cnt_n   = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Scoreboard bench for inst_fetch_resp with a byte ROM
// and a word-level reference model.
module tb_inst_fetch_resp;

  localparam int          AW  = 17;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [31:0]   pc;
  logic          flush;
  logic [31:0]   inst;
  logic          valid;
  logic          mis;
  logic          stall;
  logic [AW-1:0] mem_a;
  logic          mem_re;
  logic [7:0]    din = 8'h00;

  logic [7:0]  rom [0:(1<<AW)-1];
  logic [32:0] expq[$];
  logic [31:0] model_inst;
  int          ncmp = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  inst_fetch_resp #(
    .ADDR_W   (AW),
    .NOP_INST (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce),
    .pc_i         (pc),
    .flush_i      (flush),
    .inst_o       (inst),
    .inst_valid_o (valid),
    .misalign_o   (mis),
    .stall_req_o  (stall),
    .mem_a_o      (mem_a),
    .mem_re_o     (mem_re),
    .mem_din_i    (din)
  );

  always @(posedge clk) begin : inst_rom_byte
    if (mem_re) din <= rom[mem_a];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Word at a byte address, little-endian, address space wraps.
  function automatic logic [31:0] exp_word(input logic [31:0] p);
    logic [AW-1:0] a0, a1, a2, a3;
    a0 = p[AW-1:0];
    a1 = a0 + 17'd1;
    a2 = a0 + 17'd2;
    a3 = a0 + 17'd3;
    return {rom[a3], rom[a2], rom[a1], rom[a0]};
  endfunction

  task automatic monitor();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (expq.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL unexpected_valid: got inst %h, required no pulse", inst);
        end else begin
          e = expq.pop_front();
          chk("inst", inst, e[31:0]);
          chk("misalign", 32'(mis), 32'(e[32]));
        end
      end else if (mis !== 1'b0) begin
        ncmp++;
        nerr++;
        $display("FAIL misalign_alone: got %b required 0", mis);
      end
    end
  endtask

  // fl/rs: edge index 1..5 after accept on which flush/reset hits; 0 = none.
  task automatic fetch(input logic [31:0] p, input int fl, input int rs);
    logic [31:0]   w;
    logic [AW-1:0] b;
    int            rr;
    bit            done;
    w    = exp_word(p);
    b    = p[AW-1:0];
    rr   = rs;
    done = 1'b0;
    ce   = 1'b1;
    pc   = p;
    while (!done) begin
      done = 1'b1;
      if (fl == 0 && rr == 0) expq.push_back({1'b0, w});
      @(negedge clk);
      ce = 1'b0;
      chk("mem_a_e0", 32'(mem_a), 32'(b));
      chk("mem_re_e0", 32'(mem_re), 32'd1);
      chk("stall_e0", 32'(stall), 32'd1);
      for (int k = 1; k <= 5; k++) begin
        if (k == fl) flush = 1'b1;
        if (k == rr) begin
          rst = 1'b1;
          ce  = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        if (k == rr) begin
          rst = 1'b0;
          chk("rst_inst", inst, 32'd0);
          chk("rst_valid", 32'(valid), 32'd0);
          chk("rst_mem_a", 32'(mem_a), 32'd0);
          chk("rst_mem_re", 32'(mem_re), 32'd0);
          chk("rst_stall", 32'(stall), 32'd0);
          model_inst = 32'd0;
          rr   = 0;
          done = 1'b0;
          break;
        end
        if (k == fl) begin
          chk("flush_stall", 32'(stall), 32'd0);
          chk("flush_mem_re", 32'(mem_re), 32'd0);
          chk("flush_inst_hold", inst, model_inst);
          return;
        end
        if (k <= 3) begin
          chk("mem_a_seq", 32'(mem_a), 32'(b + AW'(k)));
          chk("mem_re_on", 32'(mem_re), 32'd1);
        end
        if (k == 4) chk("mem_re_off", 32'(mem_re), 32'd0);
        chk("stall_busy", 32'(stall), (k < 5) ? 32'd1 : 32'd0);
      end
    end
    model_inst = w;
  endtask

  task automatic b2b(input logic [31:0] pa, input logic [31:0] pb);
    logic [31:0] wb;
    wb = exp_word(pb);
    ce = 1'b1;
    pc = pa;
    expq.push_back({1'b0, exp_word(pa)});
    @(negedge clk);
    pc = pb;
    expq.push_back({1'b0, wb});
    repeat (5) @(negedge clk);
    chk("b2b_gap_stall", 32'(stall), 32'd0);
    chk("b2b_gap_mem_re", 32'(mem_re), 32'd0);
    chk("b2b_gap_valid", 32'(valid), 32'd1);
    @(negedge clk);
    ce = 1'b0;
    chk("b2b_second_a", 32'(mem_a), 32'(pb[AW-1:0]));
    chk("b2b_second_stall", 32'(stall), 32'd1);
    repeat (5) @(negedge clk);
    model_inst = wb;
  endtask

  task automatic misalign(input logic [31:0] p);
    ce = 1'b1;
    pc = p;
    expq.push_back({1'b1, NOP});
    @(negedge clk);
    ce = 1'b0;
    chk("mis_mem_re", 32'(mem_re), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    model_inst = NOP;
  endtask

  initial begin
    logic [31:0] p;
    logic [31:0] q;
    int          kind;
    for (int i = 0; i < (1 << AW); i++) rom[i] = 8'($urandom);
    rom[17'h100] = 8'h93; rom[17'h101] = 8'h00;
    rom[17'h102] = 8'h10; rom[17'h103] = 8'h00;
    rom[17'h104] = 8'h13; rom[17'h105] = 8'h01;
    rom[17'h106] = 8'h20; rom[17'h107] = 8'h00;
    rst = 1'b1;
    ce = 1'b0;
    flush = 1'b0;
    pc = 32'd0;
    model_inst = 32'd0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("reset_inst", inst, 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_mis", 32'(mis), 32'd0);
    chk("reset_mem_a", 32'(mem_a), 32'd0);
    chk("reset_mem_re", 32'(mem_re), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    fetch(32'h0000_0100, 0, 0);
    chk("aligned_word", inst, 32'h0010_0093);
    b2b(32'h0000_0100, 32'h0000_0104);
    chk("b2b_word", inst, 32'h0020_0113);
    misalign(32'h0000_0102);
    @(negedge clk);
    chk("mis_word_hold", inst, NOP);
    fetch(32'h0000_0100, 3, 0);
    fetch(32'h0000_0104, 0, 0);
    chk("after_flush_word", inst, 32'h0020_0113);
    fetch(32'h0002_0000, 0, 0);
    fetch(32'h0001_FFFC, 0, 0);
    fetch(32'hFFFF_FFFC, 0, 0);
    fetch(32'h0000_0100, 0, 2);
    chk("after_reset_word", inst, 32'h0010_0093);
    fetch(32'h0000_0104, 5, 0);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      p = $urandom;
      p[1:0] = 2'b00;
      q = $urandom;
      q[1:0] = 2'b00;
      case (kind)
        5: misalign(p | 32'($urandom_range(1, 3)));
        6: b2b(p, q);
        7: fetch(p, $urandom_range(1, 5), 0);
        8: fetch(p, 0, $urandom_range(1, 5));
        9: repeat ($urandom_range(1, 3)) @(negedge clk);
        default: fetch(p, 0, 0);
      endcase
    end

    repeat (8) @(negedge clk);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    chk("final_inst_hold", inst, model_inst);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
